dram_ctrl: RTL



---
 rtl/wrap030_dram_pkg.sv | 61 ++++++
 rtl/dram_ctrl_if.sv | 12 +
 rtl/dram_refresh_timer.sv | 32 +++
 rtl/dram_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/wrap030_dram_pkg.sv
// Shared types and helpers for the Wrap030 FPM DRAM controller.
// Imported by the controller RTL and by its testbench model.
package wrap030_dram_pkg;

    typedef enum logic [2:0] {
        sIDL,
        sROW,
        sCAS,
        sACK,
        sRF1,
        sRF2,
        sPRE
    } dram_state_t;

    // 68030 SIZ[1:0] encodings
    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // Field order matches cpuAddr[22:0], so a plain cast splits it.
    typedef struct packed {
        logic       bank;
        logic [9:0] row;
        logic [9:0] col;
        logic [1:0] a10;
    } dram_addr_t;

    function automatic dram_addr_t split_addr(input logic [22:0] a);
        return dram_addr_t'(a);
    endfunction

    // Active-high byte-lane enables, bit 3 = D31:24. Reads always use all lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a10,
                                             input logic rwn);
        logic [3:0] m;
        m = 4'b1111;
        if (!rwn) begin
            case (a10)
                2'b00:
                    case (siz)
                        SIZ_BYTE:  m = 4'b1000;
                        SIZ_WORD:  m = 4'b1100;
                        SIZ_3BYTE: m = 4'b1110;
                        SIZ_LONG:  m = 4'b1111;
                        default:   m = 4'b1111;
                    endcase
                2'b01:
                    case (siz)
                        SIZ_BYTE: m = 4'b0100;
                        SIZ_WORD: m = 4'b0110;
                        default:  m = 4'b0111;
                    endcase
                2'b10:   m = (siz == SIZ_BYTE) ? 4'b0010 : 4'b0011;
                default: m = 4'b0001;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// CPU-side handshake between the Wrap030 bus controller and the DRAM controller.
interface dram_ctrl_if;
    logic        ramCEn;
    logic        cpuASn;
    logic        cpuRWn;
    logic [1:0]  cpuSIZ;
    logic [22:0] cpuAddr;
    logic        ramACKn;

    modport master (output ramCEn, cpuASn, cpuRWn, cpuSIZ, cpuAddr, input ramACKn);
    modport slave  (input ramCEn, cpuASn, cpuRWn, cpuSIZ, cpuAddr, output ramACKn);
endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer; raises refReq once per REFRESH_DIV clocks
// and holds it until the controller acknowledges. Missed intervals do not queue.
module dram_refresh_timer #(
    parameter int REFRESH_DIV = 390
) (
    input  logic sysClk,
    input  logic sysRESET,
    input  logic refAck,
    output logic refReq
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refCnt;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysClk or posedge sysRESET) begin
        if (sysRESET) begin
            refCnt <= RELOAD;
            refReq <= 1'b0;
        end else if (refCnt == '0) begin
            // A new request wins over an acknowledge landing on the same edge.
            refCnt <= RELOAD;
            refReq <= 1'b1;
        end else begin
            refCnt <= refCnt - 1'b1;
            if (refAck) refReq <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// FPM DRAM controller behind the Wrap030 bus controller: two 32-bit banks,
// row/column multiplexing, per-lane CAS and CAS-before-RAS refresh.
module dram_ctrl
    import wrap030_dram_pkg::*;
#(
    parameter int REFRESH_DIV = 390,
    parameter int CAS_WAIT    = 1,
    parameter int PRECHARGE   = 2,
    parameter int REF_HOLD    = 2
) (
    input  logic       sysClk,
    input  logic       sysRESET,
    dram_ctrl_if.slave cpuBus,
    output logic [9:0] dramAddr,
    output logic [1:0] dramRASn,
    output logic [3:0] dramCASn,
    output logic       dramWEn
);

    localparam logic [2:0] CAS_LOAD  = 3'(CAS_WAIT);
    localparam logic [2:0] PRE_LOAD  = 3'(PRECHARGE);
    localparam logic [2:0] HOLD_LOAD = 3'(REF_HOLD);

    dram_state_t state, stateNext;
    logic [2:0]  waitCnt, cntNext;
    logic [9:0]  addrNext;
    logic [1:0]  rasNext;
    logic [3:0]  casNext;
    logic        weNext, ackNext;
    logic        refReq, refAck;
    logic        closeOut;
    logic        cpuGone, cntDone;
    dram_addr_t  cpuA;

    assign cpuA    = split_addr(cpuBus.cpuAddr);
    assign cpuGone = cpuBus.cpuASn;
    assign cntDone = (waitCnt == 3'd1);

    dram_refresh_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) uRefresh (
        .sysClk  (sysClk),
        .sysRESET(sysRESET),
        .refAck  (refAck),
        .refReq  (refReq)
    );

    always_ff @(posedge sysClk or posedge sysRESET) begin
        if (sysRESET) state <= sIDL;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            sIDL: begin
                if (refReq)                                    stateNext = sRF1;
                else if (!cpuBus.ramCEn && !cpuBus.cpuASn)     stateNext = sROW;
            end
            sROW:    stateNext = cpuGone ? sPRE : sCAS;
            sCAS: begin
                if (cpuGone)      stateNext = sPRE;
                else if (cntDone) stateNext = sACK;
            end
            sACK:    if (cpuGone) stateNext = sPRE;
            sRF1:    stateNext = sRF2;
            sRF2:    if (cntDone) stateNext = sPRE;
            sPRE:    if (cntDone) stateNext = sIDL;
            default: stateNext = sIDL;
        endcase
    end

    // Next values for the registered pins; closeOut raises every strobe and starts precharge.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        addrNext = dramAddr;
        rasNext  = dramRASn;
        casNext  = dramCASn;
        weNext   = dramWEn;
        ackNext  = cpuBus.ramACKn;
        cntNext  = waitCnt;
        refAck   = 1'b0;
        closeOut = 1'b0;
        case (state)
            sIDL: begin
                if (refReq) begin
                    casNext = 4'h0;
                    refAck  = 1'b1;
                end else if (!cpuBus.ramCEn && !cpuBus.cpuASn) begin
                    addrNext = cpuA.row;
                    rasNext  = cpuA.bank ? 2'b01 : 2'b10;
                    weNext   = cpuBus.cpuRWn;
                end
            end
            sROW: begin
                if (cpuGone) closeOut = 1'b1;
                else begin
                    addrNext = cpuA.col;
                    casNext  = ~lane_mask(cpuBus.cpuSIZ, cpuA.a10, cpuBus.cpuRWn);
                    cntNext  = CAS_LOAD;
                end
            end
            sCAS: begin
                if (cpuGone)      closeOut = 1'b1;
                else if (cntDone) ackNext  = 1'b0;
                else              cntNext  = waitCnt - 3'd1;
            end
            sACK: closeOut = cpuGone;
            sRF1: begin
                rasNext = 2'b00;
                cntNext = HOLD_LOAD;
            end
            sRF2: begin
                if (cntDone) closeOut = 1'b1;
                else         cntNext  = waitCnt - 3'd1;
            end
            sPRE:    if (!cntDone) cntNext = waitCnt - 3'd1;
            default: ;
        endcase
        if (closeOut) begin
            rasNext = 2'b11;
            casNext = 4'hF;
            weNext  = 1'b1;
            ackNext = 1'b1;
            cntNext = PRE_LOAD;
        end
    end

    always_ff @(posedge sysClk or posedge sysRESET) begin
        if (sysRESET) begin
            dramAddr       <= '0;
            dramRASn       <= 2'b11;
            dramCASn       <= 4'hF;
            dramWEn        <= 1'b1;
            cpuBus.ramACKn <= 1'b1;
            waitCnt        <= '0;
        end else begin
            dramAddr       <= addrNext;
            dramRASn       <= rasNext;
            dramCASn       <= casNext;
            dramWEn        <= weNext;
            cpuBus.ramACKn <= ackNext;
            waitCnt        <= cntNext;
        end
    end

endmodule
